// File: rtl/audio_pkg.sv
// Shared definitions for the I2S DAC serializer: default sample width,
// serializer state encoding and the unity gain value for the fade-in.
package audio_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int GAIN_UNITY     = 256;
  localparam int GAIN_W         = 9;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/edge_sync.sv
// Brings one asynchronous codec clock into the clk_50 domain through a
// SYNC_STAGES flop chain plus a history flop, and produces single-cycle
// rise/fall pulses from the synchronized level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic ar,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // Synchronizer chain followed by a history flop for edge detection
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/i2s_dac_serializer.sv
// Mono I2S serializer for the codec DAC. The codec is clock master: bclk and
// daclrck are oversampled in the clk_50 domain. The sample is captured on each
// falling daclrck (left half) and replayed in the right half, MSB first with
// the I2S one-bit delay, and zero-padded to the end of each half-frame.
// Optional fade-in gain is enabled with the macro I2S_FADE_EN.
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int SYNC_STAGES   = 2,
  parameter int FADE_LEN_LOG2 = 8
) (
  input  logic              clk_50,
  input  logic              ar,
  input  logic              bclk,
  input  logic              daclrck,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              key_on,
  output logic              dacdat,
  output logic              sample_strobe,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic bclk_level, bclk_rise, bclk_fall;
  logic lrck_level, lrck_rise, lrck_fall, lrck_edge;

  ser_state_t        state, state_d;
  logic [DATA_W-1:0] shift_reg, shift_d;
  logic [DATA_W-1:0] held, held_d;
  logic [CNT_W-1:0]  bit_cnt, cnt_d, cnt_inc;
  logic              dacdat_d;
  logic              frame_err_d;
  logic [DATA_W-1:0] word;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk   (clk_50),
    .ar    (ar),
    .din   (bclk),
    .level (bclk_level),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk   (clk_50),
    .ar    (ar),
    .din   (daclrck),
    .level (lrck_level),
    .rise  (lrck_rise),
    .fall  (lrck_fall)
  );

  assign lrck_edge     = lrck_fall | lrck_rise;
  assign sample_strobe = lrck_fall;
  assign cnt_inc       = bit_cnt + 1'b1;

`ifdef I2S_FADE_EN
  localparam int PROD_W   = DATA_W + GAIN_W + 1;
  localparam int GAIN_SHR = 8;
  localparam logic [GAIN_W-1:0] GAIN_MAX  = GAIN_W'(GAIN_UNITY);
  localparam logic [GAIN_W-1:0] GAIN_STEP = GAIN_W'(GAIN_UNITY >> FADE_LEN_LOG2);

  logic [GAIN_W-1:0] gain;

  // Signed sample times unsigned gain, arithmetic shift by 8, truncated
  function automatic logic [DATA_W-1:0] scale_word(input logic [DATA_W-1:0] s,
                                                   input logic [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] g_ext;
    logic signed [PROD_W-1:0] prod;
    s_ext = {{(PROD_W-DATA_W){s[DATA_W-1]}}, s};
    g_ext = {{(PROD_W-GAIN_W){1'b0}}, g};
    prod  = s_ext * g_ext;
    return prod[DATA_W+GAIN_SHR-1:GAIN_SHR];
  endfunction

  // Gain ramp that stops at unity
  function automatic logic [GAIN_W-1:0] gain_step_sat(input logic [GAIN_W-1:0] g);
    if (g > GAIN_MAX - GAIN_STEP) return GAIN_MAX;
    else return g + GAIN_STEP;
  endfunction

  // Fade gain: cleared while the note is off, ramps once per frame while on
  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      gain <= '0;
    end else if (!key_on) begin
      gain <= '0;
    end else if (lrck_fall) begin
      gain <= gain_step_sat(gain);
    end
  end

  assign word = scale_word(sample_in, gain);

  logic unused_sig;
  assign unused_sig = ^{bclk_level, bclk_rise, lrck_level};
`else
  assign word = sample_in;

  logic unused_sig;
  assign unused_sig = ^{bclk_level, bclk_rise, lrck_level, key_on};
`endif

  // Next-state and datapath decode; an lrck edge always wins over a
  // coincident bclk fall so the MSB lands one bit clock after the edge
  always_comb begin
    state_d     = state;
    shift_d     = shift_reg;
    cnt_d       = bit_cnt;
    held_d      = held;
    dacdat_d    = dacdat;
    frame_err_d = 1'b0;

    if (lrck_fall) held_d = word;

    case (state)
      ALIGN: begin
        dacdat_d = 1'b0;
        if (lrck_fall) begin
          shift_d = word;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT, PAD: begin
        if (lrck_edge) begin
          frame_err_d = (state == SHIFT) && (bit_cnt < CNT_FULL);
          shift_d     = lrck_fall ? word : held;
          cnt_d       = '0;
          state_d     = SHIFT;
        end else if (bclk_fall) begin
          if (state == SHIFT) begin
            dacdat_d = shift_reg[DATA_W-1];
            shift_d  = {shift_reg[DATA_W-2:0], 1'b0};
            cnt_d    = cnt_inc;
            if (cnt_inc == CNT_FULL) state_d = PAD;
          end else begin
            dacdat_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ALIGN;
        dacdat_d = 1'b0;
      end
    endcase
  end

  // Serializer state, shift register, held sample and registered outputs
  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      state     <= ALIGN;
      shift_reg <= '0;
      held      <= '0;
      bit_cnt   <= '0;
      dacdat    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      held      <= held_d;
      bit_cnt   <= cnt_d;
      dacdat    <= dacdat_d;
      frame_err <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: a codec model drives bclk/daclrck (64 bit
// clocks per frame at ~3.07 MHz) and pushes the expected dacdat value of
// every bit slot into a queue; a monitor pops and compares on each rising
// bclk, where the codec would sample DACDAT.
`timescale 1ns/100ps
module tb_i2s_dac_serializer;

  localparam int DATA_W = 16;

  logic              clk_50 = 1'b0;
  logic              ar;
  logic              bclk;
  logic              daclrck;
  logic [DATA_W-1:0] sample_in;
  logic              key_on;
  logic              dacdat;
  logic              sample_strobe;
  logic              frame_err;

  i2s_dac_serializer #(
    .DATA_W        (DATA_W),
    .SYNC_STAGES   (2),
    .FADE_LEN_LOG2 (8)
  ) dut (
    .clk_50        (clk_50),
    .ar            (ar),
    .bclk          (bclk),
    .daclrck       (daclrck),
    .sample_in     (sample_in),
    .key_on        (key_on),
    .dacdat        (dacdat),
    .sample_strobe (sample_strobe),
    .frame_err     (frame_err)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic b;
    int   half;
    int   slot;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;

  // reference model state
  logic              aligned = 1'b0;
  logic              last_bit = 1'b0;
  logic [DATA_W-1:0] held_m = '0;
  int                gain_m = 0;
  int                half_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s);
`ifdef I2S_FADE_EN
    int si;
    si = $signed(s);
    return 16'((si * gain_m) >>> 8);
`else
    return s;
`endif
  endfunction

  task automatic set_key(input logic v);
    key_on = v;
    if (!v) gain_m = 0;
  endtask

  // One half-frame of len bit slots; lrck changes on the first falling bclk
  task automatic run_half(input int len, input logic left, input int rst_slot,
                          input int rel_slot, input int chg_slot,
                          input logic [DATA_W-1:0] chg_val);
    logic e;
    for (int j = 0; j < len; j++) begin
      bclk = 1'b0;
      if (j == 0) begin
        daclrck = left ? 1'b0 : 1'b1;
        if (left && !ar) begin
          held_m  = scale(sample_in);
          aligned = 1'b1;
          if (key_on) gain_m = (gain_m + 1 > 256) ? 256 : gain_m + 1;
        end
      end
      #100;
      if (j == rst_slot) begin
        ar = 1'b1;
        #1;
        check("dacdat_async_reset", {31'd0, dacdat}, 32'd0);
        aligned  = 1'b0;
        last_bit = 1'b0;
        gain_m   = 0;
      end else begin
        #1;
      end
      if (j == rel_slot) ar = 1'b0;
      if (j == chg_slot) sample_in = chg_val;
      if (!aligned)     e = 1'b0;
      else if (j == 0)  e = last_bit;
      else if (j <= 16) e = held_m[16-j];
      else              e = 1'b0;
      last_bit = e;
      exp_q.push_back('{e, half_no, j});
      #62;
      bclk = 1'b1;
      #163;
    end
    half_no++;
  endtask

  // Monitor: compare dacdat against the expected slot value at the codec's sample edge
  always @(posedge bclk) begin
    if (exp_q.size() > 0) begin : mon
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (dacdat !== e.b) begin
        n_bad++;
        $display("FAIL dacdat half %0d slot %0d: got %0b expected %0b", e.half, e.slot, dacdat, e.b);
      end
    end
  end

  // Pulse counters for sample_strobe and frame_err
  always @(negedge clk_50) begin
    if (sample_strobe === 1'b1) strobe_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  initial begin
    ar        = 1'b1;
    bclk      = 1'b1;
    daclrck   = 1'b1;
    sample_in = 16'hA5C3;
    key_on    = 1'b0;
    #5;
    check("reset_dacdat", {31'd0, dacdat}, 32'd0);
    check("reset_strobe", {31'd0, sample_strobe}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    #0.5;

    // reset released mid right half: silent until the first left half
    run_half(32, 1'b0, -1, 10, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, 20, 16'h8000);
    check("strobes_align", strobe_cnt, 2);
    check("frame_err_align", ferr_cnt, 0);

    // sample_in changes mid left half: takes effect only at the next frame
    run_half(32, 1'b1, -1, -1, 8, 16'h7FFF);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, 20, 16'hC3A5);
    check("strobes_capture", strobe_cnt, 4);
    check("frame_err_capture", ferr_cnt, 0);

    // short left half of 10 bit clocks
    run_half(10, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, 20, 16'hFFFF);
    check("strobes_short", strobe_cnt, 6);
    check("frame_err_short", ferr_cnt, 1);

    // reset asserted during bit 7 of the left half, released at slot 12
    run_half(32, 1'b1, 7, 12, -1, '0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, 20, 16'h4000);
    check("strobes_reset", strobe_cnt, 8);
    check("frame_err_reset", ferr_cnt, 1);

    // key_on ramp (gain only applies when the fade build is selected)
    run_half(32, 1'b1, -1, -1, -1, '0);
    set_key(1'b1);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    set_key(1'b0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    run_half(32, 1'b1, -1, -1, -1, '0);
    run_half(32, 1'b0, -1, -1, -1, '0);
    check("strobes_fade", strobe_cnt, 13);
    check("frame_err_fade", ferr_cnt, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
